// File: rtl/cmplx_mult_seq.sv
// cmplx_mult_seq
//   Sequential complex multiplier: P = A*B (conj=0) or P = A*conj(B) (conj=1).
//   One signed W x W multiplier and one add/sub stage are shared over four
//   cycles. Valid/ready handshakes are used on both the input and the output.
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    operand handshake; in_ready is high only in IDLE
//   conj                   conjugate-B select, captured on accept
//   a_r, a_i, b_r, b_i     signed W-bit operands, captured on accept
//   out_valid / out_ready  result handshake; the result holds under backpressure
//   p_r, p_i               signed 2W+1-bit result
module cmplx_mult_seq #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                conj,
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [2*W:0] p_r,
  output logic signed [2*W:0] p_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_RR  = 3'd1,
    S_II  = 3'd2,
    S_RI  = 3'd3,
    S_IR  = 3'd4,
    S_OUT = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic signed [W-1:0]   ar_r, ai_r, br_r, bi_r;
  logic                  conj_r;
  logic signed [2*W-1:0] pp_r;

  logic signed [W-1:0]   mul_a_s, mul_b_s;
  logic signed [2*W-1:0] mul_a_ext_s, mul_b_ext_s, prod_s;
  logic signed [2*W:0]   add_x_s, add_y_s, addsub_s;
  logic                  sub_s;
  logic                  accept_s;

  assign accept_s = (state_r == IDLE) && in_valid;

  // Next-state logic for the four-step multiply sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = S_RR;
        else          state_s = IDLE;
      end
      S_RR:  state_s = S_II;
      S_II:  state_s = S_RI;
      S_RI:  state_s = S_IR;
      S_IR:  state_s = S_OUT;
      S_OUT: begin
        if (out_ready) state_s = IDLE;
        else           state_s = S_OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand select for the shared multiplier, driven from the current step
  always_comb begin
    mul_a_s = ar_r;
    mul_b_s = br_r;
    case (state_r)
      S_RR:    begin mul_a_s = ar_r; mul_b_s = br_r; end
      S_II:    begin mul_a_s = ai_r; mul_b_s = bi_r; end
      S_RI:    begin mul_a_s = ar_r; mul_b_s = bi_r; end
      S_IR:    begin mul_a_s = ai_r; mul_b_s = br_r; end
      default: begin mul_a_s = ar_r; mul_b_s = br_r; end
    endcase
  end

  // Operands are sign-extended to 2W so the truncated product is exact
  assign mul_a_ext_s = {{W{mul_a_s[W-1]}}, mul_a_s};
  assign mul_b_ext_s = {{W{mul_b_s[W-1]}}, mul_b_s};
  assign prod_s      = mul_a_ext_s * mul_b_ext_s;

  // Shared add/sub: real step is pp -/+ prod, imag step is prod +/- pp
  always_comb begin
    add_x_s = {pp_r[2*W-1], pp_r};
    add_y_s = {prod_s[2*W-1], prod_s};
    sub_s   = 1'b0;
    if (state_r == S_II) begin
      add_x_s = {pp_r[2*W-1], pp_r};
      add_y_s = {prod_s[2*W-1], prod_s};
      sub_s   = ~conj_r;
    end else begin
      add_x_s = {prod_s[2*W-1], prod_s};
      add_y_s = {pp_r[2*W-1], pp_r};
      sub_s   = conj_r;
    end
    if (sub_s) addsub_s = add_x_s - add_y_s;
    else       addsub_s = add_x_s + add_y_s;
  end

  // State register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == S_OUT);
    end
  end

  // Operand capture on accept; inputs are free to change while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_r   <= {W{1'b0}};
      ai_r   <= {W{1'b0}};
      br_r   <= {W{1'b0}};
      bi_r   <= {W{1'b0}};
      conj_r <= 1'b0;
    end else if (accept_s) begin
      ar_r   <= a_r;
      ai_r   <= a_i;
      br_r   <= b_r;
      bi_r   <= b_i;
      conj_r <= conj;
    end
  end

  // Partial product and result registers, one update per sequence step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_r <= {(2*W){1'b0}};
      p_r  <= {(2*W+1){1'b0}};
      p_i  <= {(2*W+1){1'b0}};
    end else begin
      case (state_r)
        S_RR:    pp_r <= prod_s;
        S_II:    p_r  <= addsub_s;
        S_RI:    pp_r <= prod_s;
        S_IR:    p_i  <= addsub_s;
        default: pp_r <= pp_r;
      endcase
    end
  end

endmodule
